// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding an 8-bit UART transmitter through a start/busy handshake.
// The transmitter's busy flag comes from the baud clock domain and is synchronised before any decision uses it.
module uart_tx_feeder #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   clear_err,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   tx_en,
    input  logic                   tx_busy,
    output logic                   sent,
    output logic                   overflow,
    output logic                   tx_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    tx_data_q;
    logic          tx_start_q, tx_start_d;
    logic          sent_q, sent_d;
    logic          overflow_q, overflow_d;
    logic          tx_err_q, tx_err_d;
    logic          tx_en_q;
    logic          busy_meta_q, busy_s_q;
    logic          full_w, empty_w, push, pop, timeout_hit;

    assign full_w  = (count_q == (AW+1)'(DEPTH));
    assign empty_w = (count_q == '0);
    // A full FIFO refuses the write even if the same cycle pops, and flush beats both.
    assign push    = wr_en & ~full_w & ~flush;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        tx_start_d  = tx_start_q;
        sent_d      = 1'b0;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !empty_w && !flush) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    timer_d    = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                timer_d = timer_q + TW'(1);
                if (busy_s_q) begin
                    tx_start_d = 1'b0;
                    state_d    = ACTIVE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    tx_start_d  = 1'b0;
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
            end
            ACTIVE: begin
                if (!busy_s_q) begin
                    sent_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
        // Setting a sticky flag takes priority over clearing it.
        overflow_d = (wr_en & full_w) | (overflow_q & ~clear_err);
        tx_err_d   = timeout_hit | (tx_err_q & ~clear_err);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            sent_q      <= 1'b0;
            overflow_q  <= 1'b0;
            tx_err_q    <= 1'b0;
            tx_en_q     <= 1'b0;
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tx_start_q  <= tx_start_d;
            sent_q      <= sent_d;
            overflow_q  <= overflow_d;
            tx_err_q    <= tx_err_d;
            tx_en_q     <= enable;
            busy_meta_q <= tx_busy;
            busy_s_q    <= busy_meta_q;
            if (pop) tx_data_q <= mem_q[rd_ptr_q];
        end
    end

    assign full     = full_w;
    assign empty    = empty_w;
    assign count    = count_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign tx_en    = tx_en_q;
    assign sent     = sent_q;
    assign overflow = overflow_q;
    assign tx_err   = tx_err_q;
endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte-queue and handshake stage that sits directly upstream of the 8-bit UART transmitter. It accepts bytes from the peripheral bus side into a FIFO on the system clock. It presents one byte at a time to the transmitter through a start/busy handshake, and because the transmitter runs on the slower baud clock, it synchronises the returned `busy` status. It reports fill level, completion, overflow and handshake-timeout status to the peripheral register block.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `TIMEOUT`, 1024: system-clock cycles allowed between `tx_start` rise and synchronised `tx_busy` rise; ≥ 4.
- `clk` in 1: system clock; one clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: push `wr_data` when not full.
- `wr_data` in 8: byte to queue.
- `enable` in 1: permit launching new bytes; an in-flight byte always completes.
- `flush` in 1: discard all queued (not in-flight) bytes.
- `clear_err` in 1: clear `overflow` and `tx_err`.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `count` out $clog2(DEPTH)+1: queued bytes, excluding the in-flight byte.
- `tx_start` out 1: start request to transmitter (level, held until acknowledged).
- `tx_data` out 8: byte presented to transmitter; stable while `tx_start` high and while busy.
- `tx_en` out 1: transmitter enable, registered copy of `enable`.
- `tx_busy` in 1: transmitter busy, baud-clock domain (asynchronous here).
- `sent` out 1: one-cycle pulse per completed byte.
- `overflow` out 1: sticky; write attempted while full.
- `tx_err` out 1: sticky; handshake timeout occurred.

## Operation
- FIFO: circular buffer, read/write pointers of $clog2(DEPTH) bits, wrap modulo DEPTH; `count` held separately.
- Write accepted iff `wr_en & ~full`. `full` blocks a write even when a pop occurs in the same cycle. A write while full sets `overflow` and leaves the FIFO unchanged.
- `busy_s`: 2-flop synchroniser of `tx_busy`, reset 0. All FSM decisions use `busy_s` only.
- FSM states: IDLE, REQ, ACTIVE.
- IDLE: if `enable & ~empty` → pop head into `tx_data`, `tx_start`←1, timer←0, go REQ.
- REQ: `tx_start` held 1; timer increments. If `busy_s`=1 → `tx_start`←0, go ACTIVE. Else if timer == TIMEOUT−1 → `tx_start`←0, `tx_err`←1, byte dropped, go IDLE.
- ACTIVE: `tx_start`=0; when `busy_s`=0 → `sent` pulses 1 cycle, go IDLE.
- `flush` resets pointers and `count` to 0. It does not affect the FSM, `tx_data` or an in-flight byte. If `flush` and `wr_en` occur in the same cycle, the flush wins and the write is dropped. If a flush coincides with an IDLE pop, the flush wins and no launch occurs.
- `clear_err` clears both sticky flags. If a set event and `clear_err` occur in the same cycle, the set wins.
- Deasserting `enable` only blocks the IDLE→REQ transition.

## Timing
- Reset values: `full`=0, `empty`=1, `count`=0, `tx_start`=0, `tx_data`=0x00, `tx_en`=0, `sent`=0, `overflow`=0, `tx_err`=0; FSM=IDLE; pointers=0. Reset applies immediately on `rst_n` fall, including mid-transfer; the in-flight byte and the queued bytes are lost.
- Push at edge N: `count`/`empty` update after edge N.
- Launch latency, empty FIFO, IDLE, `enable`=1: write at edge N; `tx_start`=1 and `tx_data` valid after edge N+1; `count` returns to 0 after edge N+1.
- `busy_s` lags `tx_busy` by 2–3 cycles. `tx_start` falls 1 cycle after `busy_s` rises.
- `sent` is high for exactly the cycle after `busy_s` is sampled low in ACTIVE.
- Back-to-back launch: the earliest next `tx_start` is 1 cycle after `sent`. The transmitter therefore always sees `tx_start` low between bytes, which guarantees it detects a fresh rising edge.
- At most one byte is in flight; the effective capacity is DEPTH+1.

## Test plan
- Reset, then single write of 0xA5 with a baud model (busy high 10 baud clocks, baud = clk/8) → `tx_start` rises 2 cycles after the write, `tx_data`=0xA5, one `sent` pulse, `count` returns to 0, `empty`=1.
- Burst of 16 writes (0x00–0x0F) with `enable`=0, then one more write → `full`=1, `count`=16, `overflow`=1. Then `enable`=1 → bytes 0x00–0x0F delivered in order and 16 `sent` pulses.
- `tx_busy` tied 0 with one byte queued → `tx_start` high for exactly TIMEOUT cycles, then low; `tx_err`=1; byte dropped; `empty`=1. Then `clear_err` → `tx_err`=0.
- `flush` asserted in ACTIVE with 5 bytes queued → `count`=0 next cycle, the in-flight byte still completes with one `sent` pulse, and no further `tx_start` follows.
- `rst_n` dropped mid-ACTIVE with 3 bytes queued → all outputs at reset values immediately. After release with `enable`=1, `tx_start` stays low.
- `wr_en` while full in the same cycle as an IDLE pop → the write is rejected, `overflow`=1, `count`=15.
